seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_pkg.sv | 26 ++
 rtl/seg_scan_driver_bcd_counter4.sv | 45 ++++
 rtl/seg_scan_driver.sv | 88 ++++++++
 3 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 8-digit seven-segment display driver:
// segment codes, the blank pattern and the default per-digit hold time.
package seg_scan_driver_pkg;

  localparam int SCAN_DIV_DEFAULT = 100000;

  localparam logic [7:0] BLANK = 8'hFF;

  // Active-low segment codes, dp off; entry [n] is the numeral n.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef logic [2:0] digitIdx_t;

  function automatic logic [7:0] segCode(input logic [3:0] digit);
    logic [7:0] code;
    code = BLANK;
    if (digit <= 4'd9) begin
      code = SEG_TABLE[digit];
    end
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_counter4.sv
// Four-digit BCD generation counter with synchronous clear that wins over
// a simultaneous increment; wraps 9999 -> 0000.
module bcd_counter4 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        clear_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Ripple the increment through the digits; a digit at 9 rolls to 0 and
  // passes the carry on, so 9999 naturally wraps to 0000.
  always_comb begin
    logic carry;
    count_d = count_q;
    carry   = inc_i;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clear_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Scans eight common-anode digits: generation count on digits 0..3 with
// leading-zero blanking, blanks on 4..6, synchronized pattern number on 7.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gen_tick,
  input  logic        clear,
  input  logic        in1,
  input  logic        in0,
  output logic [7:0]  anode,
  output logic [7:0]  cathode,
  output logic [15:0] count_bcd
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] scanCnt_q, scanCnt_d;
  digitIdx_t        digitIdx_q, digitIdx_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [7:0]       anode_q, anode_d;
  logic [7:0]       cathode_q, cathode_d;
  logic [15:0]      countBcd;
  logic [7:0]       digitSeg;
  logic             scanWrap;

  bcd_counter4 u_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (gen_tick),
    .clear_i (clear),
    .count_o (countBcd)
  );

  assign scanWrap = (scanCnt_q == DIV_W'(SCAN_DIV - 1));

  // Segments for the digit about to be shown; higher zero digits blank out.
  always_comb begin
    digitSeg = BLANK;
    case (digitIdx_d)
      3'd0: digitSeg = segCode(countBcd[3:0]);
      3'd1: if (countBcd[15:4] != 12'd0) digitSeg = segCode(countBcd[7:4]);
      3'd2: if (countBcd[15:8] != 8'd0) digitSeg = segCode(countBcd[11:8]);
      3'd3: if (countBcd[15:12] != 4'd0) digitSeg = segCode(countBcd[15:12]);
      3'd7: digitSeg = segCode({2'b00, sync2_q});
      default: digitSeg = BLANK;
    endcase
  end

  // Anode and cathode load together only when the digit advances, so a
  // digit's segments stay frozen for its whole hold period.
  always_comb begin
    scanCnt_d  = scanWrap ? '0 : scanCnt_q + DIV_W'(1);
    digitIdx_d = scanWrap ? digitIdx_q + 3'd1 : digitIdx_q;
    anode_d    = anode_q;
    cathode_d  = cathode_q;
    if (scanWrap) begin
      anode_d   = ~(8'd1 << digitIdx_d);
      cathode_d = digitSeg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scanCnt_q  <= '0;
      digitIdx_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      anode_q    <= 8'hFE;
      cathode_q  <= segCode(4'd0);
    end else begin
      scanCnt_q  <= scanCnt_d;
      digitIdx_q <= digitIdx_d;
      sync1_q    <= {in1, in0};
      sync2_q    <= sync1_q;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
    end
  end

  assign anode     = anode_q;
  assign cathode   = cathode_q;
  assign count_bcd = countBcd;

endmodule
